// File: rtl/digit_serial_adder.sv
// digit_serial_adder
//   WIDTH-bit add/subtract unit that works through the operands DIGIT bits per
//   clock with a single registered carry between digits. Operands are taken
//   through a valid/ready handshake. The result leaves through a second
//   valid/ready handshake together with the raw carry-out and signed overflow.
//
//   Parameters:
//     WIDTH  operand/result width in bits (>= 2)
//     DIGIT  bits processed per clock; must divide WIDTH (NDIG = WIDTH/DIGIT)
//
//   Ports:
//     clk        system clock, rising edge
//     rst        synchronous active-high reset
//     in_valid   operand set present
//     in_ready   block can accept operands (IDLE)
//     a, b       operands
//     cin        carry-in (add) / borrow-in (subtract)
//     sub        0: a+b+cin, 1: a-b-cin
//     out_valid  sum/cout/overflow hold a completed result (DONE)
//     out_ready  consumer accepts the result
//     sum        result modulo 2^WIDTH
//     cout       raw carry out of the MSB (subtract: 1 = no borrow)
//     overflow   two's-complement signed overflow
//     busy       high while digits are being processed (RUN)
//
//   Latency: operands accepted at edge E give out_valid after edge E+NDIG.
//   Back-to-back throughput is one result per NDIG+2 cycles.

module digit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   op_a_r;
    logic [WIDTH-1:0]   op_b_r;
    logic [WIDTH-1:0]   res_r;
    logic               carry_r;
    logic               msb_a_r;
    logic               msb_b_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [DIGIT:0]     digit_add_s;
    logic [WIDTH-1:0]   res_next_s;
    logic               last_digit_s;
    logic               ovf_next_s;

    // Digit adder, result shift-in and overflow for the digit in flight.
    always_comb begin
        digit_add_s  = {1'b0, op_a_r[DIGIT-1:0]}
                     + {1'b0, op_b_r[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_r};
        // New digit enters at the top so that after NDIG shifts the first
        // digit computed sits in the least significant position.
        res_next_s   = (res_r >> DIGIT)
                     | (WIDTH'(digit_add_s[DIGIT-1:0]) << (WIDTH - DIGIT));
        last_digit_s = (cnt_r == CNT_W'(NDIG - 1));
        // msb_b_r holds the MSB of the (possibly inverted) B operand, so the
        // same same-sign rule covers both add and subtract.
        ovf_next_s   = (msb_a_r == msb_b_r) && (res_next_s[WIDTH-1] != msb_a_r);
    end

    // Control FSM, digit datapath and registered result/handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            op_a_r    <= {WIDTH{1'b0}};
            op_b_r    <= {WIDTH{1'b0}};
            res_r     <= {WIDTH{1'b0}};
            carry_r   <= 1'b0;
            msb_a_r   <= 1'b0;
            msb_b_r   <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= {WIDTH{1'b0}};
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + ~cin: borrow-in inverts to carry-in.
                        op_a_r   <= a;
                        op_b_r   <= sub ? ~b : b;
                        carry_r  <= sub ? ~cin : cin;
                        msb_a_r  <= a[WIDTH-1];
                        msb_b_r  <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        cnt_r    <= {CNT_W{1'b0}};
                        res_r    <= {WIDTH{1'b0}};
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= ST_RUN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    op_a_r  <= op_a_r >> DIGIT;
                    op_b_r  <= op_b_r >> DIGIT;
                    carry_r <= digit_add_s[DIGIT];
                    res_r   <= res_next_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (last_digit_s) begin
                        sum       <= res_next_s;
                        cout      <= digit_add_s[DIGIT];
                        overflow  <= ovf_next_s;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= ST_DONE;
                    end else begin
                        busy      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: one instance with DIGIT=1 and
// one with DIGIT=4 (both WIDTH=8) share clock, reset, operands and out_ready;
// each has its own in_valid and outputs.

module tb_digit_serial_adder;

    logic       clk_s = 1'b0;
    logic       rst_s;
    logic [7:0] a_s;
    logic [7:0] b_s;
    logic       cin_s;
    logic       sub_s;
    logic       out_ready_s;
    logic [1:0] in_valid_s;
    logic [1:0] in_ready_s;
    logic [1:0] out_valid_s;
    logic [1:0] cout_s;
    logic [1:0] overflow_s;
    logic [1:0] busy_s;
    logic [7:0] sum_s [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_s = ~clk_s;

    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk_s), .rst(rst_s),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .a(a_s), .b(b_s), .cin(cin_s), .sub(sub_s),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s),
        .sum(sum_s[0]), .cout(cout_s[0]), .overflow(overflow_s[0]), .busy(busy_s[0])
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk_s), .rst(rst_s),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .a(a_s), .b(b_s), .cin(cin_s), .sub(sub_s),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s),
        .sum(sum_s[1]), .cout(cout_s[1]), .overflow(overflow_s[1]), .busy(busy_s[1])
    );

    task automatic check_eq(input string tag, input string what,
                            input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h, expected %0h", tag, what, obs, exp);
        end
    endtask

    // Reference: {cout, overflow, sum} from plain arithmetic.
    function automatic logic [9:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                          input logic c, input logic s);
        logic [8:0] t;
        logic       co;
        logic       v;
        if (!s) begin
            t  = {1'b0, x} + {1'b0, y} + {8'd0, c};
            co = t[8];
            v  = (x[7] == y[7]) && (t[7] != x[7]);
        end else begin
            t  = {1'b0, x} - {1'b0, y} - {8'd0, c};
            co = ~t[8];
            v  = (x[7] != y[7]) && (t[7] != x[7]);
        end
        return {co, v, t[7:0]};
    endfunction

    // One transaction on instance k. hold = cycles out_ready stays low in DONE;
    // poke = drive in_valid with junk operands during RUN.
    task automatic run_op(input int k, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tcin, input logic tsub,
                          input logic [7:0] esum, input logic ecout, input logic eovf,
                          input int hold, input logic poke, input string tag);
        int ndig;
        int cyc;
        int nbusy;
        ndig = (k == 0) ? 8 : 2;
        out_ready_s = (hold == 0);
        @(posedge clk_s); #1;
        a_s = ta; b_s = tb; cin_s = tcin; sub_s = tsub;
        in_valid_s[k] = 1'b1;
        check_eq(tag, "in_ready_idle", in_ready_s[k], 32'd1);
        @(posedge clk_s); #1;
        in_valid_s[k] = 1'b0;
        // Scramble operands: they must have been sampled at the accept edge.
        a_s = ~ta; b_s = ta ^ 8'h5A; cin_s = ~tcin; sub_s = ~tsub;
        cyc = 0;
        nbusy = 0;
        while (!out_valid_s[k] && cyc < 40) begin
            if (busy_s[k]) nbusy++;
            if (poke) begin
                in_valid_s[k] = 1'b1;
                check_eq(tag, "in_ready_run", in_ready_s[k], 32'd0);
            end
            @(posedge clk_s); #1;
            cyc++;
        end
        in_valid_s[k] = 1'b0;
        check_eq(tag, "latency", cyc, ndig);
        check_eq(tag, "busy_cycles", nbusy, ndig);
        check_eq(tag, "busy_done", busy_s[k], 32'd0);
        check_eq(tag, "sum", sum_s[k], esum);
        check_eq(tag, "cout", cout_s[k], ecout);
        check_eq(tag, "overflow", overflow_s[k], eovf);
        check_eq(tag, "in_ready_done", in_ready_s[k], 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_s); #1;
            check_eq(tag, "hold_valid", out_valid_s[k], 32'd1);
            check_eq(tag, "hold_sum", {cout_s[k], overflow_s[k], sum_s[k]}, {ecout, eovf, esum});
            check_eq(tag, "hold_in_ready", in_ready_s[k], 32'd0);
        end
        out_ready_s = 1'b1;
        @(posedge clk_s); #1;
        check_eq(tag, "handoff_valid", out_valid_s[k], 32'd0);
        check_eq(tag, "handoff_in_ready", in_ready_s[k], 32'd1);
        check_eq(tag, "retain_sum", sum_s[k], esum);
    endtask

    initial begin
        logic [9:0] exp_r;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic       rs;
        int         seen;

        rst_s = 1'b1;
        a_s = 8'h00; b_s = 8'h00; cin_s = 1'b0; sub_s = 1'b0;
        out_ready_s = 1'b1;
        in_valid_s = 2'b00;
        repeat (3) @(posedge clk_s);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq("reset", "in_ready", in_ready_s[k], 32'd1);
            check_eq("reset", "out_valid", out_valid_s[k], 32'd0);
            check_eq("reset", "busy", busy_s[k], 32'd0);
            check_eq("reset", "result", {cout_s[k], overflow_s[k], sum_s[k]}, 32'd0);
        end
        rst_s = 1'b0;

        // DIGIT=1 directed vectors
        run_op(0, 8'h3C, 8'h5A, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1, 0, 1'b0, "d1_add");
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1'b0, "d1_7f_1");
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, "d1_ff_1");
        run_op(0, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 0, 1'b0, "d1_0_m1");
        run_op(0, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 5, 1'b0, "d1_bp_sub");
        run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0, 1'b0, "d1_80_m1");

        // Reset mid-RUN: accept FF+01, assert rst two cycles later.
        out_ready_s = 1'b1;
        @(posedge clk_s); #1;
        a_s = 8'hFF; b_s = 8'h01; cin_s = 1'b0; sub_s = 1'b0;
        in_valid_s[0] = 1'b1;
        @(posedge clk_s); #1;
        in_valid_s[0] = 1'b0;
        @(posedge clk_s); #1;
        @(posedge clk_s); #1;
        check_eq("rst_run", "busy_before", busy_s[0], 32'd1);
        rst_s = 1'b1;
        @(posedge clk_s); #1;
        rst_s = 1'b0;
        check_eq("rst_run", "out_valid", out_valid_s[0], 32'd0);
        check_eq("rst_run", "in_ready", in_ready_s[0], 32'd1);
        check_eq("rst_run", "busy", busy_s[0], 32'd0);
        check_eq("rst_run", "sum", sum_s[0], 32'd0);
        check_eq("rst_run", "cout", cout_s[0], 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_s); #1;
            if (out_valid_s[0]) seen++;
        end
        check_eq("rst_run", "no_result", seen, 32'd0);

        // DIGIT=4 directed vectors
        run_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, "d4_ff_1");
        run_op(1, 8'h3C, 8'h5A, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1, 0, 1'b1, "d4_add");
        run_op(1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 3, 1'b0, "d4_bp_sub");

        // Randomised operands on both instances against the reference.
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 150; n++) begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
                exp_r = ref_op(ra, rb, rc, rs);
                run_op(k, ra, rb, rc, rs, exp_r[7:0], exp_r[9], exp_r[8],
                       int'($urandom_range(0, 2)), 1'b0, (k == 0) ? "rnd_d1" : "rnd_d4");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
